// File: rtl/signal_order_gen.sv
// Turns confirmed BUY/SELL samples from an RSI comparator pair into
// ready/valid orders, with a net position limit and a post-order cooldown.
module signal_order_gen #(
  parameter int         CONFIRM   = 2,
  parameter int         COOLDOWN  = 16,
  parameter logic [7:0] ORDER_QTY = 8'd1,
  parameter int         MAX_POS   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sig_valid,
  input  logic       sig1,
  input  logic       sig2,
  output logic       ord_valid,
  input  logic       ord_ready,
  output logic       ord_side,
  output logic [7:0] ord_qty,
  output logic [7:0] position,
  output logic [7:0] drop_cnt,
  output logic       busy
);

  typedef enum logic [1:0] {ST_IDLE, ST_CONFIRM, ST_ISSUE, ST_COOLDOWN} state_t;

  localparam logic [3:0]        CONF_W = CONFIRM[3:0];
  localparam logic [7:0]        COOL_W = COOLDOWN[7:0];
  localparam logic signed [9:0] MAX_S  = 10'(MAX_POS);
  localparam logic signed [9:0] QTY_S  = $signed({2'b00, ORDER_QTY});

  state_t     state_q;
  logic [3:0] cnt_q;
  logic [7:0] timer_q;
  logic       cand_q;
  logic       ord_valid_q;
  logic       ord_side_q;
  logic [7:0] ord_qty_q;
  logic [7:0] position_q;
  logic [7:0] drop_cnt_q;
  logic       busy_q;

  // sig1 low means a trade sample; sig2 then selects buy (1) or sell (0).
  logic              is_trade;
  logic              confirm_hit;
  logic              limit_ok;
  logic signed [9:0] pos_ext;

  assign is_trade = ~sig1;
  assign pos_ext  = {{2{position_q[7]}}, position_q};
  assign limit_ok = sig2 ? ((pos_ext + QTY_S) <= MAX_S)
                         : ((pos_ext - QTY_S) >= -MAX_S);

  // The sample's side equals cand_q whenever a confirmation completes in ST_CONFIRM.
  assign confirm_hit = sig_valid && is_trade &&
                       (((state_q == ST_IDLE) && (CONFIRM == 1)) ||
                        ((state_q == ST_CONFIRM) && (sig2 == cand_q) &&
                         ((cnt_q + 4'd1) == CONF_W)));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      timer_q     <= '0;
      cand_q      <= 1'b0;
      ord_valid_q <= 1'b0;
      ord_side_q  <= 1'b0;
      ord_qty_q   <= '0;
      position_q  <= '0;
      drop_cnt_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_CONFIRM: begin
          if (confirm_hit) begin
            cnt_q <= '0;
            if (limit_ok) begin
              state_q     <= ST_ISSUE;
              ord_valid_q <= 1'b1;
              ord_side_q  <= sig2;
              ord_qty_q   <= ORDER_QTY;
              busy_q      <= 1'b1;
            end else begin
              state_q    <= ST_IDLE;
              drop_cnt_q <= drop_cnt_q + 8'd1;
            end
          end else if (sig_valid) begin
            if (!is_trade) begin
              state_q <= ST_IDLE;
              cnt_q   <= '0;
            end else if ((state_q == ST_IDLE) || (sig2 != cand_q)) begin
              cand_q  <= sig2;
              cnt_q   <= 4'd1;
              state_q <= ST_CONFIRM;
            end else begin
              cnt_q <= cnt_q + 4'd1;
            end
          end
        end
        ST_ISSUE: begin
          if (ord_ready) begin
            ord_valid_q <= 1'b0;
            ord_qty_q   <= '0;
            position_q  <= ord_side_q ? (position_q + ORDER_QTY)
                                      : (position_q - ORDER_QTY);
            if (COOLDOWN == 0) begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end else begin
              state_q <= ST_COOLDOWN;
              timer_q <= COOL_W;
            end
          end
        end
        ST_COOLDOWN: begin
          timer_q <= timer_q - 8'd1;
          if (timer_q == 8'd1) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign ord_valid = ord_valid_q;
  assign ord_side  = ord_side_q;
  assign ord_qty   = ord_qty_q;
  assign position  = position_q;
  assign drop_cnt  = drop_cnt_q;
  assign busy      = busy_q;

endmodule

// File: doc/signal_order_gen.md
SIGNAL_ORDER_GEN -- requirements
Module: signal_order_gen

Interface
REQ-001 Parameter CONFIRM, default 2: consecutive identical BUY/SELL samples required before an order is issued; legal range 1..15.
REQ-002 Parameter COOLDOWN, default 16: idle cycles enforced after each accepted order; legal range 0..255.
REQ-003 Parameter ORDER_QTY, default 1: quantity carried on every order; unsigned 8-bit.
REQ-004 Parameter MAX_POS, default 4: absolute net position limit; signed 8-bit magnitude; MAX_POS >= ORDER_QTY.
REQ-005 clk  input  1  single clock; all state updates on the rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 sig_valid  input  1  strobe; sig1/sig2 are sampled only on cycles where it is high.
REQ-008 sig1  input  1  upstream RSI comparator signal 1.
REQ-009 sig2  input  1  upstream RSI comparator signal 2.
REQ-010 ord_valid  output  1  an order is presented.
REQ-011 ord_ready  input  1  downstream accepts the order when it is high together with ord_valid.
REQ-012 ord_side  output  1  1 = buy, 0 = sell.
REQ-013 ord_qty  output  8  order quantity, always ORDER_QTY while ord_valid is high.
REQ-014 position  output  8  signed two's-complement net position.
REQ-015 drop_cnt  output  8  count of orders dropped by the position limit; wraps 255 -> 0.
REQ-016 busy  output  1  high in states ISSUE and COOLDOWN.

Function
REQ-017 Signal decode of each sampled pair (sig1,sig2): (0,1) = BUY (RSI below the low threshold); (0,0) = SELL (RSI above the high threshold); (1,0) = HOLD; (1,1) = HOLD (illegal encoding, treated as neutral).
REQ-018 FSM states: IDLE, CONFIRM, ISSUE, COOLDOWN; all outputs are registered.
REQ-019 IDLE: a BUY/SELL sample latches the candidate side and sets cnt=1; next state is CONFIRM, or the limit check (REQ-022) if CONFIRM==1. A HOLD sample leaves the state in IDLE.
REQ-020 CONFIRM, sample with the same side: cnt increments; on reaching CONFIRM, apply the limit check.
REQ-021 CONFIRM, other samples: an opposite side restarts with the new candidate and cnt=1; HOLD returns to IDLE; cycles without sig_valid hold all state.
REQ-022 Limit check: if position +/- ORDER_QTY would exceed +MAX_POS or fall below -MAX_POS, go to IDLE and increment drop_cnt; otherwise go to ISSUE.
REQ-023 Latency: ord_valid is high in the cycle immediately after the edge that samples the confirming signal.
REQ-024 ISSUE: ord_valid, ord_side and ord_qty hold stable until ord_ready is high; sig_valid is ignored.
REQ-025 Handshake cycle (ord_valid & ord_ready): position updates by +ORDER_QTY (buy) or -ORDER_QTY (sell) at that edge; ord_valid is low the next cycle; next state is COOLDOWN with timer=COOLDOWN, or IDLE if COOLDOWN==0.
REQ-026 COOLDOWN: the timer decrements each cycle; samples are ignored; at timer==1 the next state is IDLE, giving exactly COOLDOWN cycles in the state.
REQ-027 ord_ready while ord_valid is low has no effect; orders are never issued back-to-back without passing through COOLDOWN/IDLE.
REQ-028 position never leaves [-MAX_POS, +MAX_POS].

Reset
REQ-029 When rst is high at an edge: state=IDLE, cnt=0, timer=0, ord_valid=0, ord_side=0, ord_qty=0, position=0, drop_cnt=0, busy=0.
REQ-030 Reset during ISSUE or COOLDOWN abandons the order with no position change; reset has priority over a simultaneous handshake.

Verification
REQ-031 Defaults; BUY samples at cycles 1 and 2; ord_ready=1 -> ord_valid high in cycle 3 only, side=1, qty=1; position=1; busy high for 17 cycles.
REQ-032 Samples BUY, SELL, SELL -> exactly one sell order, issued after the third sample; BUY, HOLD, BUY -> no order.
REQ-033 ord_ready held low for 5 cycles during ISSUE -> ord_valid and ord_side stable throughout; position changes only on the accepting edge.
REQ-034 MAX_POS=2: four confirmed BUY sequences -> two orders accepted, position=2, drop_cnt=2; a following SELL is accepted, giving position=1.
REQ-035 Sample (1,1) during CONFIRM -> return to IDLE with no order; rst asserted during ISSUE -> ord_valid low next cycle and position unchanged.
REQ-036 COOLDOWN=0, CONFIRM=1 -> a BUY sample at every cycle with ord_ready=1 yields one order every 2 cycles until the limit is reached.
